exercise4_demux: RTL and testbench

- Inverse of the team's 3-way select/decoder: one 8-bit input stream is steered by `sel`/`cs` to one of three output channels (alpha, beta, gamma).
- Each channel has its own small FIFO and a valid/ready handshake, so a stalled consumer blocks only its own channel.
- Sits between a single producer and three independent consumers in the lab datapath.

---
 rtl/exercise4_demux.sv | 183 ++++++++++++++++++
 tb/tb_exercise4_demux.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/exercise4_demux.sv
// -----------------------------------------------------------------------------
// exercise4_demux
//
// Steers one WIDTH-bit input stream to one of three output channels (alpha,
// beta, gamma) using sel/cs. Each channel has its own first-word-fall-through
// FIFO with a valid/ready handshake, so a stalled consumer only blocks beats
// that are headed for its own channel.
//
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   sel[1:0], cs                      channel select (3 = invalid), chip select
//   in_data, in_valid, in_ready       producer side handshake
//   {alpha,beta,gamma}_data/_valid    FIFO head and non-empty flag per channel
//   {alpha,beta,gamma}_ready          consumer pops the head
//   drop_count[7:0]                   saturating count of discarded beats
//
// Parameters: DEPTH (entries per channel, power of 2, >= 2), WIDTH (data bits).
//
// Optional feature macro: EXERCISE4_DEMUX_DROP_CNT_EN
//   defined   -> drop_count counts accepted beats with cs=0 or sel=3,
//                saturating at 255, cleared only by reset.
//   undefined -> no counter logic; drop_count is tied to 0.
// -----------------------------------------------------------------------------

// Per-channel FIFO. The parent only pushes when the FIFO is not full, so no
// overflow protection is needed here. Pops on an empty FIFO are ignored.
module exercise4_demux_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             pop;

    assign valid = (count != '0);
    assign full  = (count == CW'(DEPTH));
    assign data  = storage[rd_ptr];
    assign pop   = valid && ready;

    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the values from before this edge, independent of order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the storage array is cleared on reset because the head is
            // visible on data even when empty, and it must read 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                storage[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                storage[wr_ptr] <= push_data;
                wr_ptr          <= wr_ptr + PW'(1);   // wraps modulo DEPTH
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            // Simultaneous push and pop leaves count unchanged.
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

module exercise4_demux #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sel,
    input  logic             cs,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] alpha_data,
    output logic             alpha_valid,
    input  logic             alpha_ready,
    output logic [WIDTH-1:0] beta_data,
    output logic             beta_valid,
    input  logic             beta_ready,
    output logic [WIDTH-1:0] gamma_data,
    output logic             gamma_valid,
    input  logic             gamma_ready,
    output logic [7:0]       drop_count
);
    logic [2:0] full;
    logic [3:0] full_ext;
    logic [2:0] push;
    logic       accept;

    // Index 3 (invalid select) never reports full, so discards are never stalled.
    assign full_ext = {1'b0, full};

    // Depends only on sel, cs and the full flags: a full channel stays blocked
    // even if its consumer pops this cycle, keeping *_ready off this path.
    assign in_ready = !cs || (sel == 2'd3) || !full_ext[sel];
    assign accept   = in_valid && in_ready;

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        push = '0;
        case (sel)
            2'd0:    push[0] = accept && cs;
            2'd1:    push[1] = accept && cs;
            2'd2:    push[2] = accept && cs;
            default: push    = '0;
        endcase
    end

    exercise4_demux_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_alpha (
        .clk       (clk),
        .reset     (reset),
        .push      (push[0]),
        .push_data (in_data),
        .full      (full[0]),
        .data      (alpha_data),
        .valid     (alpha_valid),
        .ready     (alpha_ready)
    );

    exercise4_demux_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_beta (
        .clk       (clk),
        .reset     (reset),
        .push      (push[1]),
        .push_data (in_data),
        .full      (full[1]),
        .data      (beta_data),
        .valid     (beta_valid),
        .ready     (beta_ready)
    );

    exercise4_demux_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_gamma (
        .clk       (clk),
        .reset     (reset),
        .push      (push[2]),
        .push_data (in_data),
        .full      (full[2]),
        .data      (gamma_data),
        .valid     (gamma_valid),
        .ready     (gamma_ready)
    );

`ifdef EXERCISE4_DEMUX_DROP_CNT_EN
    logic       discard;
    logic [7:0] drop_cnt;

    assign discard = accept && (!cs || (sel == 2'd3));

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= 8'd0;
        end else if (discard && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign drop_count = drop_cnt;
`else
    assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_exercise4_demux.sv
// -----------------------------------------------------------------------------
// tb_exercise4_demux
//
// Directed bench for exercise4_demux (DEPTH=2, WIDTH=8). Inputs are driven on
// the falling edge and outputs sampled 1 ns later, so each record's expected
// outputs describe the state left by the previous rising edge plus the
// combinational in_ready for the record's own inputs.
// Define EXERCISE4_DEMUX_DROP_CNT_EN for both RTL and bench to test the counter.
// -----------------------------------------------------------------------------
module tb_exercise4_demux;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic       cs;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] alpha_data, beta_data, gamma_data;
    logic       alpha_valid, beta_valid, gamma_valid;
    logic       alpha_ready, beta_ready, gamma_ready;
    logic [7:0] drop_count;

    int checks = 0;
    int errors = 0;

`ifdef EXERCISE4_DEMUX_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    exercise4_demux #(.DEPTH(2), .WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .sel         (sel),
        .cs          (cs),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .alpha_data  (alpha_data),
        .alpha_valid (alpha_valid),
        .alpha_ready (alpha_ready),
        .beta_data   (beta_data),
        .beta_valid  (beta_valid),
        .beta_ready  (beta_ready),
        .gamma_data  (gamma_data),
        .gamma_valid (gamma_valid),
        .gamma_ready (gamma_ready),
        .drop_count  (drop_count)
    );

    // Producer must hold sel/cs/in_data/in_valid while a beat is stalled.
    logic       pend = 1'b0;
    logic [1:0] p_sel;
    logic       p_cs;
    logic [7:0] p_din;
    always @(posedge clk) begin
        if (pend && !reset) begin
            assert (in_valid && sel == p_sel && cs == p_cs && in_data == p_din)
                else $error("stalled beat changed before acceptance");
        end
        pend  <= in_valid && !in_ready && !reset;
        p_sel <= sel;
        p_cs  <= cs;
        p_din <= in_data;
    end

    typedef struct {
        logic [1:0] sel;
        logic       cs;
        logic [7:0] din;
        logic       vld;
        logic       ar, br, gr;
        logic       rdy;
        logic       av;
        logic [7:0] ad;
        logic       bv;
        logic [7:0] bd;
        logic       gv;
        logic [7:0] gd;
    } vec_t;

    vec_t vecs [14];

    function automatic vec_t mk(logic [1:0] s, logic c, logic [7:0] d, logic v,
                                logic ar, logic br, logic gr, logic rdy,
                                logic av, logic [7:0] ad, logic bv, logic [7:0] bd,
                                logic gv, logic [7:0] gd);
        vec_t r;
        r.sel = s;  r.cs = c;  r.din = d;  r.vld = v;
        r.ar = ar;  r.br = br; r.gr = gr;
        r.rdy = rdy; r.av = av; r.ad = ad; r.bv = bv; r.bd = bd;
        r.gv = gv;  r.gd = gd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Waits for the falling edge, drives all inputs, then lets outputs settle.
    task automatic set_in(input logic [1:0] s, input logic c, input logic [7:0] d,
                          input logic v, input logic ar, input logic br, input logic gr);
        @(negedge clk);
        sel = s; cs = c; in_data = d; in_valid = v;
        alpha_ready = ar; beta_ready = br; gamma_ready = gr;
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int exp_drop;

        //  sel  cs din   v  ar br gr | rdy av ad     bv bd     gv gd
        // Reset/idle state, then one beat to beta.
        vecs[0]  = mk(2'd0, 0, 8'h00, 0, 0, 0, 0,  1, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        vecs[1]  = mk(2'd1, 1, 8'hA5, 1, 0, 0, 0,  1, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        vecs[2]  = mk(2'd0, 0, 8'h00, 0, 0, 0, 0,  1, 0, 8'h00, 1, 8'hA5, 0, 8'h00);
        vecs[3]  = mk(2'd0, 0, 8'h00, 0, 0, 1, 0,  1, 0, 8'h00, 1, 8'hA5, 0, 8'h00);
        // Beta now empty; head slot 1 was never written. beta_ready ignored.
        vecs[4]  = mk(2'd0, 0, 8'h00, 0, 0, 1, 0,  1, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        // Fill gamma with 11, 22; 33 then sees in_ready=0.
        vecs[5]  = mk(2'd2, 1, 8'h11, 1, 0, 0, 0,  1, 0, 8'h00, 0, 8'h00, 0, 8'h00);
        vecs[6]  = mk(2'd2, 1, 8'h22, 1, 0, 0, 0,  1, 0, 8'h00, 0, 8'h00, 1, 8'h11);
        vecs[7]  = mk(2'd2, 1, 8'h33, 0, 0, 0, 0,  0, 0, 8'h00, 0, 8'h00, 1, 8'h11);
        // Alpha beat still accepted while gamma is full.
        vecs[8]  = mk(2'd0, 1, 8'h44, 1, 0, 0, 0,  1, 0, 8'h00, 0, 8'h00, 1, 8'h11);
        // Full gamma blocks 33 even while being popped this cycle.
        vecs[9]  = mk(2'd2, 1, 8'h33, 1, 0, 0, 1,  0, 1, 8'h44, 0, 8'h00, 1, 8'h11);
        // Space freed: 33 accepted, 22 popped in the same cycle.
        vecs[10] = mk(2'd2, 1, 8'h33, 1, 0, 0, 1,  1, 1, 8'h44, 0, 8'h00, 1, 8'h22);
        vecs[11] = mk(2'd0, 0, 8'h00, 0, 0, 0, 1,  1, 1, 8'h44, 0, 8'h00, 1, 8'h33);
        // Gamma empty with rd_ptr=1 whose slot still holds 22.
        vecs[12] = mk(2'd0, 0, 8'h00, 0, 1, 0, 0,  1, 1, 8'h44, 0, 8'h00, 0, 8'h22);
        vecs[13] = mk(2'd0, 0, 8'h00, 0, 0, 0, 0,  1, 0, 8'h00, 0, 8'h00, 0, 8'h22);

        reset = 1'b1;
        sel = 2'd0; cs = 1'b0; in_data = 8'h00; in_valid = 1'b0;
        alpha_ready = 1'b0; beta_ready = 1'b0; gamma_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        check("reset drop_count", 32'(drop_count), 32'd0);

        for (int i = 0; i < 14; i++) begin
            set_in(vecs[i].sel, vecs[i].cs, vecs[i].din, vecs[i].vld,
                   vecs[i].ar, vecs[i].br, vecs[i].gr);
            check($sformatf("vec%0d in_ready", i),    32'(in_ready),    32'(vecs[i].rdy));
            check($sformatf("vec%0d alpha_valid", i), 32'(alpha_valid), 32'(vecs[i].av));
            check($sformatf("vec%0d alpha_data", i),  32'(alpha_data),  32'(vecs[i].ad));
            check($sformatf("vec%0d beta_valid", i),  32'(beta_valid),  32'(vecs[i].bv));
            check($sformatf("vec%0d beta_data", i),   32'(beta_data),   32'(vecs[i].bd));
            check($sformatf("vec%0d gamma_valid", i), 32'(gamma_valid), 32'(vecs[i].gv));
            check($sformatf("vec%0d gamma_data", i),  32'(gamma_data),  32'(vecs[i].gd));
        end

        // Continuous alpha stream with the consumer always ready: each sample
        // shows the previous beat at the head, pointers wrap many times.
        for (int i = 0; i < 16; i++) begin
            set_in(2'd0, 1'b1, 8'(i), 1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("stream%0d in_ready", i), 32'(in_ready), 32'd1);
            check($sformatf("stream%0d alpha_valid", i), 32'(alpha_valid), (i == 0) ? 32'd0 : 32'd1);
            if (i != 0) begin
                check($sformatf("stream%0d alpha_data", i), 32'(alpha_data), 32'(i - 1));
            end
        end
        set_in(2'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stream tail alpha_valid", 32'(alpha_valid), 32'd1);
        check("stream tail alpha_data",  32'(alpha_data),  32'h0F);
        set_in(2'd0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        set_in(2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stream drained alpha_valid", 32'(alpha_valid), 32'd0);

        // Discards: three with cs=0 (any sel), two with sel=3.
        for (int i = 0; i < 5; i++) begin
            if (i < 3) set_in(2'(i), 1'b0, 8'hE0 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            else       set_in(2'd3,  1'b1, 8'hE0 + 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
            check($sformatf("drop%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        set_in(2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("drop alpha_valid", 32'(alpha_valid), 32'd0);
        check("drop beta_valid",  32'(beta_valid),  32'd0);
        check("drop gamma_valid", 32'(gamma_valid), 32'd0);
        exp_drop = DROP_EN ? 5 : 0;
        check("drop_count after 5", 32'(drop_count), 32'(exp_drop));

        // 300 more discards drive the counter into saturation.
        for (int i = 0; i < 300; i++) begin
            set_in(2'd3, 1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        set_in(2'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_drop = DROP_EN ? 255 : 0;
        check("drop_count saturated", 32'(drop_count), 32'(exp_drop));
        check("drop gamma_valid after 300", 32'(gamma_valid), 32'd0);

        // Load alpha to full, then reset during a pop: nothing survives.
        set_in(2'd0, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 1'b0);
        set_in(2'd0, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        set_in(2'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("preload alpha_valid", 32'(alpha_valid), 32'd1);
        check("preload alpha_data",  32'(alpha_data),  32'h55);
        check("preload in_ready full", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        alpha_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        alpha_ready = 1'b0;
        #1;
        check("post-reset alpha_valid", 32'(alpha_valid), 32'd0);
        check("post-reset alpha_data",  32'(alpha_data),  32'h00);
        check("post-reset in_ready",    32'(in_ready),    32'd1);
        check("post-reset drop_count",  32'(drop_count),  32'd0);
        set_in(2'd0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post-reset alpha_valid later", 32'(alpha_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
